// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO write-side blocks: default word width and
// the arbiter state type.
package fifo_pkg;

    localparam int FIFO_DATA_W = 128;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin select: picks the first requester at or after ptr,
// wrapping modulo NUM_REQ.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDW-1:0]     index,
    output logic               any
);

    logic [IDW-1:0] cand;

    always_comb begin
        grant = '0;
        index = '0;
        any   = 1'b0;
        cand  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDW'((int'(ptr) + k) % NUM_REQ);
            if (!any && req[cand]) begin
                any         = 1'b1;
                grant[cand] = 1'b1;
                index       = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-locking arbiter for the shared FIFO write port; throttles on
// full/almost-full so a write is never issued into a full FIFO.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int  NUM_REQ   = 4,
    parameter int  DATA_W    = FIFO_DATA_W,
    parameter int  BURST_MAX = 4,
    localparam int IDW       = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      fifo_wren,
    output logic [DATA_W-1:0]         fifo_wdata,
    input  logic                      fifo_full,
    input  logic                      fifo_alm_full,
    output logic [IDW-1:0]            grant_id,
    output logic                      busy,
    output logic                      wr_err
);

    localparam logic [0:0] S_IDLE  = IDLE;
    localparam logic [0:0] S_BURST = BURST;

    logic [0:0]         state;
    logic [IDW-1:0]     rr_ptr;
    logic [3:0]         burst_cnt;
    logic [NUM_REQ-1:0] pick_grant;
    logic [NUM_REQ-1:0] owner_oh;
    logic [IDW-1:0]     pick_idx;
    logic [IDW-1:0]     acc_idx;
    logic               pick_any;
    logic               can_acc;
    logic               accept;
    logic [DATA_W-1:0]  acc_data;

    function automatic logic [IDW-1:0] ptr_inc(input logic [IDW-1:0] p);
        return (int'(p) == NUM_REQ - 1) ? '0 : p + 1'b1;
    endfunction

    rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .index (pick_idx),
        .any   (pick_any)
    );

    // An in-flight write may be about to consume the last free slot.
    assign can_acc = !fifo_full && !(fifo_alm_full && fifo_wren);
    assign busy    = (state == S_BURST);
    assign acc_idx = (state == S_IDLE) ? pick_idx : grant_id;
    assign accept  = |(req_valid & req_ready);

    // Handshake: a word moves when req_valid[i] && req_ready[i]; ready is offered only to the
    // IDLE winner or the BURST owner and only while the FIFO can take a word; valid never waits on ready.
    always_comb begin
        owner_oh           = '0;
        owner_oh[grant_id] = 1'b1;
        req_ready          = '0;
        if (reset && can_acc) begin
            if (state == S_IDLE) req_ready = pick_any ? pick_grant : '0;
            else                 req_ready = owner_oh;
        end
    end

    always_comb begin
        acc_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (acc_idx == IDW'(i)) acc_data = req_data[i*DATA_W +: DATA_W];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            fifo_wren  <= 1'b0;
            fifo_wdata <= '0;
            grant_id   <= '0;
            wr_err     <= 1'b0;
        end else begin
            fifo_wren <= accept;
            if (accept) fifo_wdata <= acc_data;
            if (fifo_wren && fifo_full) wr_err <= 1'b1;

            case (state)
                S_IDLE: begin
                    if (accept) begin
                        grant_id <= pick_idx;
                        if (BURST_MAX == 1) begin
                            rr_ptr <= ptr_inc(pick_idx);
                        end else begin
                            state     <= S_BURST;
                            burst_cnt <= 4'd1;
                        end
                    end
                end
                default: begin
                    // Backpressure (valid && !can_acc) falls through and holds state and count.
                    if (accept) begin
                        if (burst_cnt + 4'd1 == 4'(BURST_MAX)) begin
                            state     <= S_IDLE;
                            rr_ptr    <= ptr_inc(grant_id);
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= burst_cnt + 4'd1;
                        end
                    end else if (!req_valid[grant_id]) begin
                        state     <= S_IDLE;
                        rr_ptr    <= ptr_inc(grant_id);
                        burst_cnt <= '0;
                    end
                end
            endcase
        end
    end

endmodule
